// File: rtl/asynchronous_fifo_core.sv
// rtl/asynchronous_fifo_core.sv - single-clock FIFO with registered full/empty/half flags
//
// Purpose: DEPTH x DATA_WIDTH FIFO between a producer (write_enable/data_write)
// and a consumer (read_enable/data_read). Both sides run on wclk. All status
// flags are registered and reflect the occupancy after each rising edge.
//
// Ports:
//   wclk         in   clock, rising edge
//   wrst_n       in   asynchronous active-low reset
//   write_enable in   write request (dropped while wfull)
//   data_write   in   write data
//   read_enable  in   read request (dropped while rempty)
//   data_read    out  registered read data, holds when no read is accepted
//   wfull        out  occupancy == DEPTH
//   rempty       out  occupancy == 0
//   half_full    out  occupancy >= DEPTH/2
//   half_rempty  out  occupancy <= DEPTH/2
module asynchronous_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_read,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  half_full,
  output logic                  half_rempty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_HALF = (ADDR_WIDTH + 1)'(DEPTH / 2);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;

  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR_WIDTH:0]   w_wptr_next;
  logic [ADDR_WIDTH:0]   w_rptr_next;
  logic [ADDR_WIDTH:0]   w_occ_next;
  logic                  w_full_next;
  logic                  w_empty_next;

  // Acceptance uses the registered flags, so a write while full or a read
  // while empty is silently ignored.
  assign w_wr_accept = write_enable & ~wfull;
  assign w_rd_accept = read_enable & ~rempty;

  assign w_wptr_next = r_wptr + (ADDR_WIDTH + 1)'(w_wr_accept);
  assign w_rptr_next = r_rptr + (ADDR_WIDTH + 1)'(w_rd_accept);

  // The extra wrap bit makes the modular difference span 0..DEPTH unambiguously.
  assign w_occ_next = w_wptr_next - w_rptr_next;

  assign w_full_next  = (w_wptr_next[ADDR_WIDTH] != w_rptr_next[ADDR_WIDTH]) &&
                        (w_wptr_next[ADDR_WIDTH-1:0] == w_rptr_next[ADDR_WIDTH-1:0]);
  assign w_empty_next = (w_wptr_next == w_rptr_next);

  // Storage is never cleared; reset only makes old contents unreachable.
  always_ff @(posedge wclk) begin
    if (w_wr_accept) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_write;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      data_read   <= '0;
      wfull       <= 1'b0;
      rempty      <= 1'b1;
      half_full   <= 1'b0;
      half_rempty <= 1'b1;
    end else begin
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      if (w_rd_accept) begin
        data_read <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
      end
      wfull       <= w_full_next;
      rempty      <= w_empty_next;
      half_full   <= (w_occ_next >= LP_HALF);
      half_rempty <= (w_occ_next <= LP_HALF);
    end
  end

endmodule

// File: tb/tb_asynchronous_fifo_core.sv
// tb/tb_asynchronous_fifo_core.sv - directed self-checking bench for asynchronous_fifo_core
module tb_asynchronous_fifo_core;

  logic       wclk;
  logic       wrst_n;
  logic       write_enable;
  logic [7:0] data_write;
  logic       read_enable;
  logic [7:0] data_read;
  logic       wfull;
  logic       rempty;
  logic       half_full;
  logic       half_rempty;

  int errors;
  int checks;

  asynchronous_fifo_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .write_enable (write_enable),
    .data_write   (data_write),
    .read_enable  (read_enable),
    .data_read    (data_read),
    .wfull        (wfull),
    .rempty       (rempty),
    .half_full    (half_full),
    .half_rempty  (half_rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Expected {wfull, rempty, half_full, half_rempty} for a given occupancy.
  function automatic logic [3:0] exp_flags(input int occ);
    return {occ == 16, occ == 0, occ >= 8, occ <= 8};
  endfunction

  // Advance one rising edge and sample 1 ns later.
  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_write   = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    wrst_n = 1'b0;
    #10;
    wrst_n = 1'b1;
    #1;
    checks++;
    if ({wfull, rempty, half_full, half_rempty} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0101", {wfull, rempty, half_full, half_rempty});
    end
    checks++;
    if (data_read !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got=%h exp=00", data_read);
    end
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_enable = 1'b1;
      data_write   = 8'(i);
      cyc();
      checks++;
      if ({wfull, rempty, half_full, half_rempty} !== exp_flags(i + 1)) begin
        errors++;
        $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {wfull, rempty, half_full, half_rempty}, exp_flags(i + 1));
      end
    end
    data_write = 8'hAA;
    cyc();
    idle();
    checks++;
    if ({wfull, rempty, half_full, half_rempty} !== 4'b1010) begin
      errors++;
      $display("FAIL fill_overflow got=%b exp=1010", {wfull, rempty, half_full, half_rempty});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      read_enable = 1'b1;
      cyc();
      checks++;
      if (data_read !== 8'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_read, 8'(i));
      end
      checks++;
      if ({wfull, rempty, half_full, half_rempty} !== exp_flags(15 - i)) begin
        errors++;
        $display("FAIL drain_flags[%0d] got=%b exp=%b", i, {wfull, rempty, half_full, half_rempty}, exp_flags(15 - i));
      end
    end
    cyc();
    idle();
    checks++;
    if (data_read !== 8'h0F || rempty !== 1'b1) begin
      errors++;
      $display("FAIL drain_underflow got=%h/%b exp=0f/1", data_read, rempty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1;
      data_write   = 8'h20 + 8'(i);
      cyc();
    end
    read_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_write = 8'h28 + 8'(k);
      cyc();
      checks++;
      if (data_read !== 8'h20 + 8'(k)) begin
        errors++;
        $display("FAIL simul_data[%0d] got=%h exp=%h", k, data_read, 8'h20 + 8'(k));
      end
      checks++;
      if ({wfull, rempty, half_full, half_rempty} !== 4'b0011) begin
        errors++;
        $display("FAIL simul_flags[%0d] got=%b exp=0011", k, {wfull, rempty, half_full, half_rempty});
      end
    end
    write_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (data_read !== 8'h34 + 8'(i)) begin
        errors++;
        $display("FAIL simul_tail[%0d] got=%h exp=%h", i, data_read, 8'h34 + 8'(i));
      end
    end
    idle();
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty got=%b exp=1", rempty);
    end
  endtask

  task automatic test_boundary();
    // Both requests while empty: only the write lands.
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_write   = 8'h77;
    cyc();
    idle();
    checks++;
    if (rempty !== 1'b0 || data_read !== 8'h3B) begin
      errors++;
      $display("FAIL empty_rw got=%b/%h exp=0/3b", rempty, data_read);
    end
    read_enable = 1'b1;
    cyc();
    idle();
    checks++;
    if (data_read !== 8'h77 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_read got=%h/%b exp=77/1", data_read, rempty);
    end
    // Both requests while full: only the read lands, 0xEE is dropped.
    for (int i = 0; i < 16; i++) begin
      write_enable = 1'b1;
      data_write   = 8'h80 + 8'(i);
      cyc();
    end
    read_enable = 1'b1;
    data_write  = 8'hEE;
    cyc();
    idle();
    checks++;
    if (wfull !== 1'b0 || data_read !== 8'h80) begin
      errors++;
      $display("FAIL full_rw got=%b/%h exp=0/80", wfull, data_read);
    end
    read_enable = 1'b1;
    for (int i = 1; i < 16; i++) begin
      cyc();
      checks++;
      if (data_read !== 8'h80 + 8'(i)) begin
        errors++;
        $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, data_read, 8'h80 + 8'(i));
      end
    end
    idle();
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_empty got=%b exp=1", rempty);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin
      write_enable = 1'b1;
      data_write   = 8'hC0 + 8'(i);
      cyc();
    end
    write_enable = 1'b0;
    read_enable  = 1'b1;
    cyc();
    idle();
    checks++;
    if (data_read !== 8'hC0) begin
      errors++;
      $display("FAIL midrst_pre got=%h exp=c0", data_read);
    end
    #1;
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({wfull, rempty, half_full, half_rempty} !== 4'b0101 || data_read !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async got=%b/%h exp=0101/00", {wfull, rempty, half_full, half_rempty}, data_read);
    end
    #1;
    wrst_n = 1'b1;
    write_enable = 1'b1;
    data_write   = 8'h5A;
    cyc();
    write_enable = 1'b0;
    read_enable  = 1'b1;
    cyc();
    idle();
    checks++;
    if (data_read !== 8'h5A || rempty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after got=%h/%b exp=5a/1", data_read, rempty);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wrst_n = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundary();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
